// File: rtl/shift_cmd_fifo.sv
// Shift command FIFO: first-word-fall-through queue of {operand, shift amount}
// pairs that feeds the A/S inputs of a barrel shifter.
module shift_cmd_fifo #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SHAMT_W-1:0]     in_shamt,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SHAMT_W-1:0]     out_shamt,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0]  dataMem_q  [DEPTH];
  logic [SHAMT_W-1:0] shamtMem_q [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Ready depends only on registered occupancy, so a pop never opens a slot
  // for a push in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = out_valid ? dataMem_q[rdPtr_q]  : '0;
  assign out_shamt = out_valid ? shamtMem_q[rdPtr_q] : '0;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_ONE;
      if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      dataMem_q[wrPtr_q]  <= in_data;
      shamtMem_q[wrPtr_q] <= in_shamt;
    end
  end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Testbench for shift_cmd_fifo: directed vector table, a hand-written
// wrap-around sequence and a randomized run against a queue-based model.
module tb_shift_cmd_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_shamt;
  logic       out_ready;
  logic [2:0] count;

  int total;
  int bad;

  typedef struct {
    logic       rstN;
    logic       flush;
    logic       inValid;
    logic [7:0] inData;
    logic [2:0] inShamt;
    logic       outReady;
    int         expCount;
    logic       expValid;
    logic       expReady;
    logic [7:0] expData;
    logic [2:0] expShamt;
  } vec_t;

  vec_t vecs[$];
  int   splitIdx;

  shift_cmd_fifo #(.DATA_W(8), .SHAMT_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after an edge; outputs are sampled at that point too.
  task automatic applyStimulus(input logic rstN, input logic fl, input logic iv,
                               input logic [7:0] d, input logic [2:0] s,
                               input logic oRdy);
    rst_n     = rstN;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    in_shamt  = s;
    out_ready = oRdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int eCount, input logic eValid,
                          input logic eReady, input logic [7:0] eData,
                          input logic [2:0] eShamt);
    checkOutput({tag, ".count"},     int'(count),     eCount);
    checkOutput({tag, ".out_valid"}, int'(out_valid), int'(eValid));
    checkOutput({tag, ".in_ready"},  int'(in_ready),  int'(eReady));
    checkOutput({tag, ".out_data"},  int'(out_data),  int'(eData));
    checkOutput({tag, ".out_shamt"}, int'(out_shamt), int'(eShamt));
  endtask

  task automatic addVec(input logic rstN, input logic fl, input logic iv,
                        input logic [7:0] d, input logic [2:0] s, input logic oRdy,
                        input int c, input logic v, input logic r,
                        input logic [7:0] ed, input logic [2:0] es);
    vec_t t;
    t.rstN = rstN; t.flush = fl; t.inValid = iv; t.inData = d; t.inShamt = s;
    t.outReady = oRdy; t.expCount = c; t.expValid = v; t.expReady = r;
    t.expData = ed; t.expShamt = es;
    vecs.push_back(t);
  endtask

  task automatic runVecs(input int first, input int last);
    for (int i = first; i < last; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].flush, vecs[i].inValid,
                    vecs[i].inData, vecs[i].inShamt, vecs[i].outReady);
      checkAll($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expValid,
               vecs[i].expReady, vecs[i].expData, vecs[i].expShamt);
    end
  endtask

  initial begin
    logic [10:0] model[$];
    logic        rRst, rFl, rIv, rOr;
    logic [7:0]  rD, eD;
    logic [2:0]  rS, eS;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    out_ready = 1'b0;

    // Reset, three pushes, drain, then overflow attempt at full with a pop.
    addVec(0, 0, 0, 8'h00, 3'd0, 0, 0, 0, 1, 8'h00, 3'd0);
    addVec(1, 0, 1, 8'hB1, 3'd3, 0, 1, 1, 1, 8'hB1, 3'd3);
    addVec(1, 0, 1, 8'h2B, 3'd4, 0, 2, 1, 1, 8'hB1, 3'd3);
    addVec(1, 0, 1, 8'hF6, 3'd5, 0, 3, 1, 1, 8'hB1, 3'd3);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 2, 1, 1, 8'h2B, 3'd4);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 1, 1, 1, 8'hF6, 3'd5);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 8'h00, 3'd0);
    addVec(1, 0, 1, 8'h11, 3'd1, 0, 1, 1, 1, 8'h11, 3'd1);
    addVec(1, 0, 1, 8'h22, 3'd2, 0, 2, 1, 1, 8'h11, 3'd1);
    addVec(1, 0, 1, 8'h33, 3'd3, 0, 3, 1, 1, 8'h11, 3'd1);
    addVec(1, 0, 1, 8'h44, 3'd4, 0, 4, 1, 0, 8'h11, 3'd1);
    addVec(1, 0, 1, 8'hAA, 3'd7, 1, 3, 1, 1, 8'h22, 3'd2);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 2, 1, 1, 8'h33, 3'd3);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 1, 1, 1, 8'h44, 3'd4);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 8'h00, 3'd0);
    splitIdx = vecs.size();
    // Flush beats a push; reset discards held entries; empty pop is ignored.
    addVec(1, 0, 1, 8'h60, 3'd0, 0, 3, 1, 1, 8'h56, 3'd6);
    addVec(1, 1, 1, 8'h61, 3'd1, 0, 0, 0, 1, 8'h00, 3'd0);
    addVec(1, 0, 1, 8'h70, 3'd2, 0, 1, 1, 1, 8'h70, 3'd2);
    addVec(1, 0, 1, 8'h71, 3'd3, 0, 2, 1, 1, 8'h70, 3'd2);
    addVec(0, 0, 1, 8'h72, 3'd4, 1, 0, 0, 1, 8'h00, 3'd0);
    addVec(1, 0, 1, 8'h01, 3'd1, 0, 1, 1, 1, 8'h01, 3'd1);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 8'h00, 3'd0);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 8'h00, 3'd0);
    addVec(1, 0, 1, 8'h80, 3'd6, 1, 1, 1, 1, 8'h80, 3'd6);
    addVec(1, 0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 8'h00, 3'd0);

    runVecs(0, splitIdx);

    // Hold two entries and push+pop together for six cycles so pointers wrap.
    applyStimulus(1, 0, 1, 8'h50, 3'd0, 0);
    checkAll("wrapFill0", 1, 1, 1, 8'h50, 3'd0);
    applyStimulus(1, 0, 1, 8'h51, 3'd1, 0);
    checkAll("wrapFill1", 2, 1, 1, 8'h50, 3'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 1, 8'h52 + 8'(k), 3'(2 + k), 1);
      checkAll($sformatf("wrap%0d", k), 2, 1, 1, 8'h51 + 8'(k), 3'(1 + k));
    end

    runVecs(splitIdx, vecs.size());

    // Randomized traffic against a queue model; the first cycle forces a reset.
    model.delete();
    for (int n = 0; n < 400; n++) begin
      rRst = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      rFl  = ($urandom_range(0, 24) == 0);
      rIv  = ($urandom_range(0, 2) != 0);
      rOr  = ($urandom_range(0, 2) != 0);
      rD   = 8'($urandom);
      rS   = 3'($urandom);
      if (!rRst || rFl) begin
        model.delete();
      end else begin
        automatic bit doPush = rIv && (model.size() < 4);
        automatic bit doPop  = rOr && (model.size() != 0);
        if (doPop)  void'(model.pop_front());
        if (doPush) model.push_back({rD, rS});
      end
      applyStimulus(rRst, rFl, rIv, rD, rS, rOr);
      eD = (model.size() != 0) ? model[0][10:3] : 8'h00;
      eS = (model.size() != 0) ? model[0][2:0]  : 3'd0;
      checkAll($sformatf("rand%0d", n), model.size(), model.size() != 0,
               model.size() < 4, eD, eS);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
